// File: rtl/dual_port_ram.sv
// Dual-port RAM: byte-enabled read/write data port plus a read-only fetch port.
// Define DUAL_PORT_RAM_CLEAR_ON_RESET_EN to zero the array after every reset.
module dpr_byte_merge (
  input  logic       en,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] out_b
);
  assign out_b = en ? new_b : old_b;
endmodule

module dual_port_ram #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    read_write,
  input  logic [ADDRESS_SIZE-1:0] address,
  input  logic [DATA_SIZE-1:0]    data_in,
  input  logic [DATA_SIZE/8-1:0]  byte_en,
  output logic [DATA_SIZE-1:0]    data_out,
  output logic                    ack,
  input  logic                    fetch_en,
  input  logic [ADDRESS_SIZE-1:0] fetch_address,
  output logic [DATA_SIZE-1:0]    fetch_out,
  output logic                    fetch_valid,
  output logic                    ready
);
  localparam int LANES = DATA_SIZE / 8;
  localparam int DEPTH = 1 << ADDRESS_SIZE;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [DATA_SIZE-1:0] old_word;
  logic [DATA_SIZE-1:0] wr_word;
  logic                 acc_rd;
  logic                 acc_wr;
  logic                 acc_fetch;
`ifdef DUAL_PORT_RAM_CLEAR_ON_RESET_EN
  logic [ADDRESS_SIZE-1:0] clr_addr;
`endif

  assign ready     = (state == IDLE);
  assign acc_rd    = ready && req && read_write;
  assign acc_wr    = ready && req && !read_write;
  assign acc_fetch = ready && fetch_en;
  assign old_word  = mem[address];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dpr_byte_merge u_merge (
      .en   (byte_en[i]),
      .old_b(old_word[8*i +: 8]),
      .new_b(data_in[8*i +: 8]),
      .out_b(wr_word[8*i +: 8])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CLEAR;
      ack         <= 1'b0;
      fetch_valid <= 1'b0;
      data_out    <= '0;
      fetch_out   <= '0;
`ifdef DUAL_PORT_RAM_CLEAR_ON_RESET_EN
      clr_addr    <= '0;
`endif
    end else begin
      ack         <= acc_rd || acc_wr;
      fetch_valid <= acc_fetch;
      if (acc_rd) data_out <= mem[address];
      // Fetch sees the merged word when it collides with a same-cycle write.
      if (acc_fetch)
        fetch_out <= (acc_wr && fetch_address == address) ? wr_word : mem[fetch_address];
      if (state == CLEAR) begin
`ifdef DUAL_PORT_RAM_CLEAR_ON_RESET_EN
        clr_addr <= clr_addr + 1'b1;
        if (&clr_addr) state <= IDLE;
`else
        state <= IDLE;
`endif
      end
    end
  end

  // The array itself is never reset; clearing walks one word per cycle.
  always_ff @(posedge clk) begin
    if (acc_wr) mem[address] <= wr_word;
`ifdef DUAL_PORT_RAM_CLEAR_ON_RESET_EN
    else if (state == CLEAR && !reset) mem[clr_addr] <= '0;
`endif
  end
endmodule

// File: tb/tb_dual_port_ram.sv
// Randomized + directed check of dual_port_ram against a word-array reference model.
module tb_dual_port_ram;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;
`ifdef DUAL_PORT_RAM_CLEAR_ON_RESET_EN
  localparam int CLR = DEPTH;
`else
  localparam int CLR = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          read_write;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [3:0]    byte_en;
  logic [DW-1:0] data_out;
  logic          ack;
  logic          fetch_en;
  logic [AW-1:0] fetch_address;
  logic [DW-1:0] fetch_out;
  logic          fetch_valid;
  logic          ready;

  dual_port_ram #(.DATA_SIZE(DW), .ADDRESS_SIZE(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .read_write(read_write),
    .address(address), .data_in(data_in), .byte_en(byte_en),
    .data_out(data_out), .ack(ack), .fetch_en(fetch_en),
    .fetch_address(fetch_address), .fetch_out(fetch_out),
    .fetch_valid(fetch_valid), .ready(ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] e_dout, e_fout;
  logic          e_ack, e_fv;
  bit            m_ready;
  int            m_wait;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ack"}, {31'd0, ack}, {31'd0, e_ack});
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
    chk({tag, ".data_out"}, data_out, e_dout);
    chk({tag, ".fetch_out"}, fetch_out, e_fout);
    chk({tag, ".ready"}, {31'd0, ready}, {31'd0, m_ready});
  endtask

  // Model one clock edge using the inputs currently applied, then check the DUT.
  task automatic tick(input string tag);
    logic [DW-1:0] mask, nw;
    bit ad, af;
    ad = m_ready && req && !reset;
    af = m_ready && fetch_en && !reset;
    mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    nw = (ref_mem[address] & ~mask) | (data_in & mask);
    e_ack = ad;
    e_fv  = af;
    if (ad && read_write) e_dout = ref_mem[address];
    if (af) e_fout = (ad && !read_write && fetch_address == address) ? nw : ref_mem[fetch_address];
    if (ad && !read_write) ref_mem[address] = nw;
    if (!m_ready && !reset) begin
      m_wait--;
      if (m_wait == 0) begin
        m_ready = 1'b1;
`ifdef DUAL_PORT_RAM_CLEAR_ON_RESET_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
      end
    end
    @(posedge clk); #1;
    chk_all(tag);
  endtask

  task automatic idle();
    req = 0; read_write = 0; address = '0; data_in = '0; byte_en = '0;
    fetch_en = 0; fetch_address = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    req = 1; read_write = 0; address = a; data_in = d; byte_en = be;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    req = 1; read_write = 1; address = a;
  endtask

  task automatic assert_reset();
    reset = 1; #1;
    e_ack = 0; e_fv = 0; e_dout = '0; e_fout = '0;
    m_ready = 0; m_wait = CLR;
    chk_all("reset_now");
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!m_ready && n < 100) begin tick(tag); n++; end
    chk({tag, ".clear_len"}, n, CLR);
  endtask

  initial begin
    idle();
    reset = 1;
    m_ready = 0; m_wait = CLR;
    e_ack = 0; e_fv = 0; e_dout = '0; e_fout = '0;
    #3;
    assert_reset();
    tick("hold_reset");
    tick("hold_reset");
    reset = 0;

    // Requests during CLEAR must be dropped entirely.
    wr(4'd9, 32'hFFFF_FFFF, 4'hF);
    fetch_en = 1; fetch_address = 4'd9;
    wait_ready("clear1");
    idle();

`ifdef DUAL_PORT_RAM_CLEAR_ON_RESET_EN
    for (int i = 0; i < DEPTH; i++) begin rd(i[AW-1:0]); tick("zero_rd"); end
    rd(4'd7); tick("rd7");
    chk("rd7_const", data_out, 32'h0);
`else
    for (int i = 0; i < DEPTH; i++) begin wr(i[AW-1:0], $urandom, 4'hF); tick("init_wr"); end
`endif

    wr(4'd3, 32'hDEAD_BEEF, 4'hF); tick("wr3_full");
    wr(4'd3, 32'h0000_00AA, 4'h1); tick("wr3_lane0");
    wr(4'd3, 32'h5555_5555, 4'h0); tick("wr3_nolane");
    rd(4'd3); tick("rd3");
    chk("rd3_const", data_out, 32'hDEAD_BEAA);

    wr(4'd5, 32'h1234_5678, 4'hF); fetch_en = 1; fetch_address = 4'd5;
    tick("wr_fetch5");
    chk("fetch5_const", fetch_out, 32'h1234_5678);
    idle();

    for (int i = 0; i < 4; i++) begin rd(i[AW-1:0]); tick("b2b_rd"); end
    idle(); tick("b2b_end");

    for (int i = 0; i < 300; i++) begin
      req = $urandom_range(0, 1); read_write = $urandom_range(0, 1);
      address = $urandom_range(0, DEPTH - 1); data_in = $urandom; byte_en = $urandom_range(0, 15);
      fetch_en = $urandom_range(0, 1);
      fetch_address = ($urandom_range(0, 3) == 0) ? address : 4'($urandom_range(0, DEPTH - 1));
      tick("rand");
    end
    idle();

    // Reset the cycle after an accepted read: pending ack is dropped.
    wr(4'd3, 32'hDEAD_BEAA, 4'hF); tick("rewr3");
    rd(4'd3); tick("rd_before_rst");
    assert_reset();
    idle();
    tick("rst2_hold");
    reset = 0;
    wait_ready("clear2");
    rd(4'd3); tick("rd3_after_rst");
`ifdef DUAL_PORT_RAM_CLEAR_ON_RESET_EN
    chk("rd3_after_rst_const", data_out, 32'h0);
`else
    chk("rd3_after_rst_const", data_out, 32'hDEAD_BEAA);
`endif
    idle(); tick("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
